// File: rtl/isqrt_pipe.sv
// Fully pipelined floor(sqrt(x)): restoring digit-by-digit method, one root bit per stage.
// Fixed latency of N/2 cycles, one argument per cycle, results in issue order.
module isqrt_pipe #(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [N-1:0]     x,
  output logic             y_vld,
  output logic [N/2-1:0]   y
);

  localparam int unsigned H  = N / 2;
  localparam int unsigned RW = H + 2;

  logic          vld_q  [H];
  logic [RW-1:0] rem_q  [H];
  logic [H-1:0]  root_q [H];
  logic [N-1:0]  xs_q   [H];

  logic          in_vld  [H];
  logic [RW-1:0] in_rem  [H];
  logic [H-1:0]  in_root [H];
  logic [N-1:0]  in_xs   [H];

  // Stage inputs: stage 0 starts from the raw argument, later stages chain.
  always_comb begin
    in_vld[0]  = x_vld;
    in_rem[0]  = '0;
    in_root[0] = '0;
    in_xs[0]   = x;
    for (int s = 1; s < int'(H); s++) begin
      in_vld[s]  = vld_q[s-1];
      in_rem[s]  = rem_q[s-1];
      in_root[s] = root_q[s-1];
      in_xs[s]   = xs_q[s-1];
    end
  end

  for (genvar s = 0; s < int'(H); s++) begin : g_stage
    logic [RW-1:0] cur;
    logic [RW-1:0] trial;
    logic          ge;

    // rem stays <= 2*root+1, so its two top bits are zero and the shift cannot overflow.
    assign cur   = {in_rem[s][RW-3:0], in_xs[s][N-1:N-2]};
    assign trial = {in_root[s], 2'b01};
    assign ge    = (cur >= trial);

    // Data holds unless the upstream stage presents a valid argument.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[s]  <= 1'b0;
        rem_q[s]  <= '0;
        root_q[s] <= '0;
        xs_q[s]   <= '0;
      end else begin
        vld_q[s] <= in_vld[s];
        if (in_vld[s]) begin
          rem_q[s]  <= ge ? RW'(cur - trial) : cur;
          root_q[s] <= {in_root[s][H-2:0], ge};
          xs_q[s]   <= {in_xs[s][N-3:0], 2'b00};
        end
      end
    end
  end

  assign y_vld = vld_q[H-1];
  assign y     = root_q[H-1];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Scoreboard bench for isqrt_pipe (N=32): directed vectors, bubbles, resets, random traffic.
module tb_isqrt_pipe;

  localparam int unsigned N   = 32;
  localparam int unsigned H   = N / 2;
  localparam int unsigned LAT = H;

  logic          clk;
  logic          rst;
  logic          x_vld;
  logic [N-1:0]  x;
  logic          y_vld;
  logic [H-1:0]  y;

  isqrt_pipe #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] x;
    logic [H-1:0] y;
    int unsigned  t;
  } ent_t;

  ent_t        sb[$];
  ent_t        e;
  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned n_in;
  int unsigned n_out;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void check(input bit ok, input string name,
                                input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endfunction

  // Reference floor-sqrt by binary search on 64-bit squares.
  function automatic logic [H-1:0] sqrt_ref(input logic [N-1:0] v);
    longint lo, hi, mid;
    lo = 0;
    hi = (longint'(1) << H) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return H'(lo);
  endfunction

  // Monitor: pop and compare each result the DUT presents.
  always @(negedge clk) begin
    if (!rst && y_vld) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_y_vld", 1, 0);
      end else begin
        e = sb.pop_front();
        n_out++;
        check(y == e.y, "y_value", longint'(y), longint'(e.y));
        check(cyc == e.t + LAT, "latency", longint'(cyc - e.t), longint'(LAT));
        check((longint'(y) * longint'(y) <= longint'(e.x)) &&
              ((longint'(y) + 1) * (longint'(y) + 1) > longint'(e.x)),
              "root_bounds", longint'(y), longint'(e.x));
      end
    end
  end

  task automatic send(input logic [N-1:0] v, input logic [H-1:0] exp);
    ent_t n;
    @(negedge clk);
    x_vld = 1'b1;
    x     = v;
    n.x = v; n.y = exp; n.t = cyc;
    sb.push_back(n);
    n_in++;
  endtask

  task automatic idle(input int unsigned cycles);
    repeat (cycles) begin
      @(negedge clk);
      x_vld = 1'b0;
      x     = $urandom;
    end
  endtask

  task automatic flush();
    n_in = n_in - sb.size();
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    #1;
    check(sb.size() == 0, "drain_timeout", sb.size(), 0);
  endtask

  logic [N-1:0] rx;
  bit           bub [7] = '{1, 0, 1, 1, 0, 0, 1};
  logic [N-1:0] bx  [4] = '{32'd50, 32'd81, 32'd200, 32'd65535};
  logic [H-1:0] by  [4] = '{16'd7, 16'd9, 16'd14, 16'd255};

  initial begin
    n_chk = 0; n_pass = 0; n_in = 0; n_out = 0;
    x_vld = 1'b0;
    x     = '0;
    rst   = 1'b1;
    #1;
    check(y_vld == 1'b0, "reset_y_vld", y_vld, 0);
    check(y == '0, "reset_y", y, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing emerges, y stays 0.
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (i % 10 == 9) begin
        check(y_vld == 1'b0, "idle_y_vld", y_vld, 0);
        check(y == '0, "idle_y", y, 0);
      end
    end

    // Single arguments with gaps, including both extremes.
    send(32'd0, 16'd0);          idle(5);
    send(32'd1, 16'd1);          idle(3);
    send(32'd15, 16'd3);         idle(7);
    send(32'd16, 16'd4);         idle(2);
    send(32'd1000000, 16'd1000); idle(4);
    send(32'hFFFF_FFFF, 16'hFFFF);
    drain();

    // Back-to-back, then y holds the last result.
    send(32'd2, 16'd1);
    send(32'd3, 16'd1);
    send(32'd4, 16'd2);
    send(32'd99, 16'd9);
    send(32'd100, 16'd10);
    drain();
    idle(3);
    check(y_vld == 1'b0, "hold_y_vld", y_vld, 0);
    check(y == 16'd10, "hold_y", y, 10);

    // Bubble pattern; idle-cycle x is random and must not matter.
    for (int i = 0, k = 0; i < 7; i++) begin
      if (bub[i]) begin send(bx[k], by[k]); k++; end
      else idle(1);
    end
    drain();

    // Asynchronous reset lands mid-cycle while a result is on the output.
    send(32'd25, 16'd5);
    @(posedge clk);
    @(negedge clk);
    x_vld = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check(y_vld == 1'b1, "pre_rst_y_vld", y_vld, 1);
    check(y == 16'd5, "pre_rst_y", y, 5);
    #1;
    rst = 1'b1;
    flush();
    #1;
    check(y_vld == 1'b0, "async_rst_y_vld", y_vld, 0);
    check(y == '0, "async_rst_y", y, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-flight discards everything in the pipe.
    for (int i = 0; i < 8; i++) send(N'(i * 37 + 5), sqrt_ref(N'(i * 37 + 5)));
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    x_vld = 1'b0;
    send(32'd49, 16'd7);
    drain();
    check(y == 16'd7, "post_rst_y", y, 7);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 2) != 0) send(rx, sqrt_ref(rx));
      else idle(1);
    end
    drain();
    check(n_out == n_in, "in_out_count", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/isqrt_pipe.md
Name: isqrt_pipe

Overview:
- Fully pipelined integer square root unit: y = floor(sqrt(x)) for unsigned N-bit x.
- Sits directly downstream of the formula FSMs. Their isqrt_*_x_vld/isqrt_*_x outputs drive x_vld/x. The y_vld/y outputs return on isqrt_*_y_vld/isqrt_*_y.
- Accepts one argument per cycle with no backpressure. Fixed latency. Results return in issue order.

Parameters:
- N, 32, input width in bits; must be even and >= 4. Output width is N/2. Pipeline depth is N/2.

Ports:
- clk  input  1  clock, all registers rising-edge
- rst  input  1  reset, asynchronous, active-high
- x_vld  input  1  argument valid; sampled every rising edge; no ready, always accepted
- x  input  N  unsigned argument; meaningful only when x_vld=1
- y_vld  output  1  result valid, one-cycle pulse per accepted argument
- y  output  N/2  floor(sqrt(x)) of the corresponding argument

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst=1, every stage valid bit = 0, every stage data register = 0, y_vld=0, y=0. Effect is immediate, with no clock required.
- Algorithm: restoring digit-by-digit method, one result bit per stage, MSB first. Stage i (i=1..N/2) holds valid_i, rem_i (N/2+2 bits, unsigned), root_i (N/2 bits), xs_i (N bits, remaining argument bits left-aligned).
- Stage step:
  - cur = (rem<<2) | xs[N-1:N-2]
  - trial = (root<<2) | 1, widened to N/2+2 bits
  - if cur >= trial: rem' = cur - trial, root' = (root<<1)|1
  - else: rem' = cur, root' = root<<1
  - xs' = xs<<2
  - Stage 1 uses rem=0, root=0, xs=x.
- Width rule: rem never exceeds 2*root+1, so N/2+2 bits never overflow. Comparison and subtraction are unsigned at N/2+2 bits.
- Valid chain: valid_1 <= x_vld; valid_{i+1} <= valid_i. y_vld = valid_{N/2}. Registered output; no combinational path from x to y.
- Latency: x_vld=1 in cycle k gives y_vld=1 in cycle k+N/2 (16 for N=32), with y equal to that argument's root.
- Throughput: 1 per cycle. Back-to-back arguments produce back-to-back results. Gaps are preserved exactly.
- Data registers of a stage load only when the upstream valid is 1. Otherwise they hold. Consequence: y holds the last produced result while y_vld=0. After reset with no traffic, y=0.
- x is ignored when x_vld=0. Changing x with x_vld low has no effect on any output.
- Ordering: results emerge strictly in input order. No reordering or dropping, except on reset.
- Reset mid-operation: all in-flight arguments are discarded; no y_vld pulse for them. The first argument after rst deasserts follows normal latency.
- Boundaries:
  - x=0 -> 0.
  - x=2^N-1 -> 2^(N/2)-1. For N=32, 0xFFFFFFFF -> 0xFFFF; the rem path must not overflow.
  - Perfect squares are exact. Non-squares are floored (never rounded).
- Usage with formula FSMs: two instances, one per isqrt_1/isqrt_2. Equal latency means both results of a pair arrive in the same cycle. The FSMs must also work when results are separated by any number of cycles.

Test Plan:
- Reset then idle 40 cycles -> y_vld stays 0, y=0. Assert rst asynchronously mid-cycle -> y_vld drops without a clock edge.
- Single arguments with gaps (N=32): x=0 -> 0, 1 -> 1, 15 -> 3, 16 -> 4, 1000000 -> 1000, 0xFFFFFFFF -> 0xFFFF. Each y_vld appears exactly 16 cycles after its x_vld.
- Back-to-back: x = 2, 3, 4, 99, 100 on consecutive cycles -> y_vld high for cycles 16..20 with y = 1, 1, 2, 9, 10. Then y_vld=0 and y holds 10.
- Bubble pattern: x_vld = 1,0,1,1,0,0,1 with random x while x varies during idle cycles -> output valid pattern is identical, delayed 16 cycles. Values match the floor-sqrt model; idle-cycle x has no effect.
- Reset mid-flight: issue 8 arguments, assert rst at cycle 10 for 2 cycles -> zero result pulses. Issue x=49 afterwards -> y=7 exactly 16 cycles later.
- Random soak: 100k random x with random x_vld, plus N=8 parameter build -> every result equals floor(sqrt(x)). Also check y*y <= x < (y+1)*(y+1); count of outputs equals count of inputs.
